// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine buzzer driver.
// Holds the FSM state encoding, the default timing constants and the
// register widths used by wm_buzzer and wm_tone_gen.
package wm_pkg;

  typedef logic [1:0] buz_state_t;

  localparam buz_state_t ST_IDLE = 2'd0;
  localparam buz_state_t ST_ON   = 2'd1;
  localparam buz_state_t ST_OFF  = 2'd2;

  // Defaults: 2 kHz tone at 50 MHz, 100 ms beeps, 100 ms gaps, 3-beep melody.
  localparam int TONE_HALF_CNT_DEF = 12500;
  localparam int BEEP_ON_MS_DEF    = 100;
  localparam int BEEP_OFF_MS_DEF   = 100;
  localparam int DONE_BEEP_NUM_DEF = 3;

  localparam int MS_W   = 10;
  localparam int BEEP_W = 4;
  localparam int TONE_W = 16;

endpackage

// File: rtl/wm_tone_gen.sv
// Square-wave tone generator for the buzzer.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   restart in  forces count=0 and phase=1 (start of a tone burst)
//   en      in  count clk cycles; when low the generator parks at count=0, phase=0
//   tone    out current tone phase
module wm_tone_gen
  import wm_pkg::*;
#(
  parameter int HALF_CNT = TONE_HALF_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tone
);

  localparam logic [TONE_W-1:0] HALF_LAST = TONE_W'(HALF_CNT - 1);

  logic [TONE_W-1:0] tone_cnt_q;
  logic              phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else if (restart) begin
      tone_cnt_q <= '0;
      phase_q    <= 1'b1;
    end else if (en) begin
      if (tone_cnt_q == HALF_LAST) begin
        tone_cnt_q <= '0;
        phase_q    <= ~phase_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + 1'b1;
      end
    end else begin
      tone_cnt_q <= '0;
      phase_q    <= 1'b0;
    end
  end

  assign tone = phase_q;

endmodule

// File: rtl/wm_buzzer.sv
// Buzzer pattern driver: turns one-cycle beep/done requests into timed
// square-wave bursts on the buzzer pin, timed from the shared 1 ms tick.
// Ports:
//   clk           in  system clock
//   rst           in  asynchronous active-high reset
//   clkCnt_1msEnd in  one-cycle pulse every 1 ms
//   beep_req      in  request a single short beep
//   done_req      in  request the done melody (wins over beep_req)
//   stop          in  abort any pattern (highest priority)
//   mute          in  only when WM_BUZ_MUTE_EN is defined: silences buz_out
//                     without affecting sequencing
//   buz_out       out square-wave drive to the buzzer
//   buz_busy      out high while a pattern is in progress
// Optional feature macro: WM_BUZ_MUTE_EN
module wm_buzzer
  import wm_pkg::*;
#(
  parameter int TONE_HALF_CNT = TONE_HALF_CNT_DEF,
  parameter int BEEP_ON_MS    = BEEP_ON_MS_DEF,
  parameter int BEEP_OFF_MS   = BEEP_OFF_MS_DEF,
  parameter int DONE_BEEP_NUM = DONE_BEEP_NUM_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clkCnt_1msEnd,
  input  logic beep_req,
  input  logic done_req,
  input  logic stop,
`ifdef WM_BUZ_MUTE_EN
  input  logic mute,
`endif
  output logic buz_out,
  output logic buz_busy
);

  localparam logic [MS_W-1:0]   ON_LAST   = MS_W'(BEEP_ON_MS - 1);
  localparam logic [MS_W-1:0]   OFF_LAST  = MS_W'(BEEP_OFF_MS - 1);
  localparam logic [BEEP_W-1:0] DONE_LAST = BEEP_W'(DONE_BEEP_NUM - 1);

  buz_state_t        state_q, state_d;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic [BEEP_W-1:0] beep_left_q, beep_left_d;
  logic              tone_restart;
  logic              tone;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ms_cnt_q    <= '0;
      beep_left_q <= '0;
    end else begin
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      beep_left_q <= beep_left_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d      = state_q;
    ms_cnt_d     = ms_cnt_q;
    beep_left_d  = beep_left_q;
    tone_restart = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      ms_cnt_d    = '0;
      beep_left_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (done_req || beep_req) begin
            state_d      = ST_ON;
            ms_cnt_d     = '0;
            beep_left_d  = done_req ? DONE_LAST : '0;
            tone_restart = 1'b1;
          end
        end
        ST_ON: begin
          // A done request arriving on a single beep upgrades it to the
          // melody; the current burst restarts as the melody's first beep.
          if (done_req && beep_left_q == '0) begin
            ms_cnt_d     = '0;
            beep_left_d  = DONE_LAST;
            tone_restart = 1'b1;
          end else if (clkCnt_1msEnd) begin
            if (ms_cnt_q == ON_LAST) begin
              ms_cnt_d = '0;
              state_d  = (beep_left_q == '0) ? ST_IDLE : ST_OFF;
            end else begin
              ms_cnt_d = ms_cnt_q + 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (clkCnt_1msEnd) begin
            if (ms_cnt_q == OFF_LAST) begin
              ms_cnt_d     = '0;
              state_d      = ST_ON;
              beep_left_d  = beep_left_q - 1'b1;
              tone_restart = 1'b1;
            end else begin
              ms_cnt_d = ms_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          ms_cnt_d    = '0;
          beep_left_d = '0;
        end
      endcase
    end
  end

  // The tone keeps counting only while the FSM stays in ON, so leaving ON
  // (including via stop) clears the tone counter on the same edge.
  wm_tone_gen #(
    .HALF_CNT (TONE_HALF_CNT)
  ) u_tone (
    .clk     (clk),
    .rst     (rst),
    .restart (tone_restart),
    .en      (state_d == ST_ON),
    .tone    (tone)
  );

  // Outputs.
  always_comb begin
    buz_busy = (state_q != ST_IDLE);
`ifdef WM_BUZ_MUTE_EN
    buz_out  = (state_q == ST_ON) && tone && !mute;
`else
    buz_out  = (state_q == ST_ON) && tone;
`endif
  end

endmodule

// File: doc/wm_buzzer.md
Name: wm_buzzer

Overview:
- User-feedback output driver for the washing machine: the output-side counterpart of the button input path.
- Takes one-cycle request pulses (key-accept beep, cycle-done melody) and drives a square-wave tone on the buzzer pin with timed on/off patterns.
- Times its patterns from the shared 1 ms tick (clkCnt_1msEnd), the same tick the button block uses.
- Sits beside the main controller. Button enables and controller events are routed into its request inputs.

Parameters:
- TONE_HALF_CNT, 12500: clk cycles per tone half-period (2 kHz at 50 MHz); 16-bit counter.
- BEEP_ON_MS, 100: tone-on duration per beep, in 1 ms ticks; 1..1023.
- BEEP_OFF_MS, 100: silence between melody beeps, in 1 ms ticks; 1..1023.
- DONE_BEEP_NUM, 3: number of beeps in the done melody; 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- clkCnt_1msEnd  in  1  one-cycle pulse every 1 ms.
- beep_req  in  1  one-cycle pulse requesting a single short beep.
- done_req  in  1  one-cycle pulse requesting the done melody.
- stop  in  1  level/pulse; aborts any pattern.
- buz_out  out  1  square-wave drive to the buzzer.
- buz_busy  out  1  high while a pattern is in progress.

Behaviour:
- Reset (async, rst=1): state IDLE, all counters 0, tone phase 0, buz_out=0, buz_busy=0.
- States are IDLE, ON and OFF. Registers are ms_cnt (10b), beep_left (4b) and tone_cnt (16b).
- IDLE, with done_req=1 and stop=0 -> ON; beep_left=DONE_BEEP_NUM-1.
- IDLE, with beep_req=1 (done_req=0) and stop=0 -> ON; beep_left=0.
- If done_req and beep_req arrive in the same cycle, done_req wins.
- Entering ON:
  - ms_cnt=0, tone_cnt=0, tone phase=1.
  - buz_out is high on the first cycle after the request pulse (latency 1 clk).
- In ON:
  - tone_cnt counts clk cycles.
  - When tone_cnt reaches TONE_HALF_CNT-1, tone_cnt wraps to 0 and the tone phase toggles.
  - buz_out = tone phase while in ON, and is 0 in every other state.
- In ON, the ms tick counts:
  - On a tick with ms_cnt==BEEP_ON_MS-1, ms_cnt goes to 0.
  - If beep_left==0 -> IDLE, else -> OFF.
  - Otherwise the tick increments ms_cnt.
  - Tone duration is therefore between BEEP_ON_MS-1 and BEEP_ON_MS ms, because the tick phase is unknown.
- In OFF:
  - On a tick with ms_cnt==BEEP_OFF_MS-1 -> ON and beep_left decrements; the tone restarts with phase=1.
  - Otherwise the tick increments ms_cnt.
- buz_busy = (state != IDLE), registered with the state.
- Requests while busy:
  - beep_req is ignored.
  - done_req during a single beep (beep_left==0 in ON) upgrades the pattern: go to ON, ms_cnt=0, beep_left=DONE_BEEP_NUM-1.
  - done_req during the melody is ignored.
- stop has highest priority in every state, including over same-cycle requests. Next cycle: IDLE, buz_out=0, counters cleared.
- Reset asserted mid-pattern forces the reset values immediately. No pattern resumes after reset is released.
- All counters saturate-free. Comparisons are exact equality; the parameter ranges above guarantee no overflow.

Optional Feature:
- Macro: WM_BUZ_MUTE_EN.
- Defined:
  - Adds input port mute (1b).
  - While mute=1, buz_out is forced to 0, but sequencing, counters and buz_busy proceed unchanged. The pattern timing is identical whether muted or not.
  - Deasserting mute mid-ON resumes the tone at the current phase.
- Undefined: no mute port; buz_out as above.

Decomposition:
- Shared package wm_pkg holds:
  - state encoding localparams (IDLE=2'd0, ON=2'd1, OFF=2'd2);
  - default timing constants (1 ms tick-based ON/OFF durations);
  - tone half-count default.
- One natural sub-module: wm_tone_gen. It has inputs clk, rst, restart and en, and output tone. It holds tone_cnt and the phase toggle; restart forces phase=1 and count=0.
- The FSM and ms/beep counters stay in wm_buzzer.

Test Plan:
Sim setup: TONE_HALF_CNT=4, BEEP_ON_MS=3, BEEP_OFF_MS=2, DONE_BEEP_NUM=3, clkCnt_1msEnd every 10 clk.
1. Reset -> buz_out=0, buz_busy=0. A one-cycle beep_req -> buz_out=1 next clk, then toggles every 4 clk; returns to IDLE after the 3rd ON-state tick; buz_busy falls the same cycle.
2. One done_req -> 3 tone bursts separated by 2-tick silences. buz_out=0 throughout OFF. buz_busy stays high continuously and falls after the 3rd burst.
3. beep_req and done_req in the same cycle -> the 3-beep melody. A beep_req issued mid-melody -> no change to the pattern.
4. beep_req, then done_req 5 clk later -> ms_cnt restarts and 3 full bursts follow. A second done_req mid-melody -> ignored; still exactly 3 bursts.
5. stop during the 2nd burst of the melody -> next clk buz_out=0, buz_busy=0. stop coincident with beep_req in IDLE -> stays IDLE.
6. rst pulsed mid-ON -> outputs 0 immediately (async); after release, idle until a new request. With WM_BUZ_MUTE_EN, mute=1 during done_req -> buz_out=0 throughout while buz_busy timing matches scenario 2.
